audio_ring_writer: RTL and testbench

Captures a continuous stream of stereo PCM samples from the audio codec interface and writes them into the 32-bit on-chip sample memory as a circular buffer, using an Avalon-MM write-only master. It sits directly upstream of the on-chip memory slave (32-bit data, 15-bit word address, byteenable, chipselect, write) and absorbs interconnect stalls with a small FIFO. Software reads the published write pointer to locate the newest audio.

---
 rtl/audio_ring_writer.sv | 174 +++++++++++++++++
 tb/tb_audio_ring_writer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_ring_writer.sv
// Stereo PCM capture into a circular sample buffer through an Avalon-MM write-only master.
// Define AUDIO_RING_WRITER_PEAK_EN to add per-channel peak meters (peak_left/right, peak_clear).
module audio_ring_writer #(
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned DEPTH   = 32768,
   parameter int unsigned FIFO_AW = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [15:0]       in_left,
   input  logic [15:0]       in_right,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   output logic [31:0]       avm_writedata,
   input  logic              avm_waitrequest,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic              wrap_pulse,
   output logic [15:0]       drop_count,
   output logic              busy
`ifdef AUDIO_RING_WRITER_PEAK_EN
   ,
   input  logic              peak_clear,
   output logic [15:0]       peak_left,
   output logic [15:0]       peak_right
`endif
);

   localparam int unsigned FifoDepth = 2 ** FIFO_AW;

   typedef enum logic {StIdle, StWrite} state_e;

   state_e             r_state, w_state_nxt;
   logic [31:0]        r_mem [FifoDepth];
   logic [FIFO_AW-1:0] r_head, r_tail;
   logic [FIFO_AW:0]   r_count, w_count_nxt;
   logic               r_clr_pend, w_clr_pend_nxt;
   logic [ADDR_W-1:0]  r_wr_ptr, r_addr;
   logic [31:0]        r_data;
   logic [15:0]        r_drop;
   logic               r_wrap, r_busy;

   logic               w_accept, w_apply, w_take, w_empty, w_full, w_slot;
   logic               w_load, w_pop, w_bypass, w_push, w_drop;
   logic [ADDR_W-1:0]  w_ptr_inc, w_ptr_adv;
   logic [31:0]        w_load_data;

   assign w_accept = (r_state == StWrite) & ~avm_waitrequest;
   // A pending clear waits until no write is outstanding on the bus.
   assign w_apply  = r_clr_pend & ((r_state == StIdle) | w_accept);
   assign w_take   = in_valid & enable & ~r_clr_pend;
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == (FIFO_AW + 1)'(FifoDepth));
   assign w_slot   = (r_state == StIdle) | w_accept;
   assign w_load   = w_slot & ~r_clr_pend & (~w_empty | w_take);
   assign w_pop    = w_load & ~w_empty;
   // With an empty FIFO the incoming sample goes straight to the bus register.
   assign w_bypass = w_load & w_empty;
   assign w_push   = w_take & ~w_bypass & (~w_full | w_pop);
   assign w_drop   = w_take & ~w_bypass & w_full & ~w_pop;

   assign w_ptr_inc   = (r_wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_W'(1);
   assign w_ptr_adv   = w_accept ? w_ptr_inc : r_wr_ptr;
   assign w_load_data = w_empty ? {in_left, in_right} : r_mem[r_head];

   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_clr_pend_nxt = r_clr_pend | clear;
      unique case (r_state)
         StIdle:  if (w_load) w_state_nxt = StWrite;
         StWrite: if (w_accept) w_state_nxt = w_load ? StWrite : StIdle;
         default: w_state_nxt = StIdle;
      endcase
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (FIFO_AW + 1)'(1);
         2'b01:   w_count_nxt = r_count - (FIFO_AW + 1)'(1);
         default: w_count_nxt = r_count;
      endcase
      if (w_apply) begin
         w_count_nxt    = '0;
         w_clr_pend_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_clr_pend <= 1'b0;
         r_wr_ptr   <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_drop     <= '0;
         r_wrap     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_clr_pend <= w_clr_pend_nxt;
         r_wrap     <= w_accept & (r_wr_ptr == ADDR_W'(DEPTH - 1));
         r_busy     <= (w_count_nxt != '0) | (w_state_nxt == StWrite) | w_clr_pend_nxt;
         if (w_apply) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_wr_ptr <= '0;
            r_drop   <= '0;
         end else begin
            r_wr_ptr <= w_ptr_adv;
            if (w_push) r_tail <= r_tail + FIFO_AW'(1);
            if (w_pop) r_head <= r_head + FIFO_AW'(1);
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
         end
         if (w_load) begin
            r_addr <= w_ptr_adv;
            r_data <= w_load_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= {in_left, in_right};
   end

   assign avm_address    = r_addr;
   assign avm_writedata  = r_data;
   assign avm_write      = (r_state == StWrite);
   assign avm_chipselect = (r_state == StWrite);
   assign avm_byteenable = 4'hF;
   assign wr_ptr         = r_wr_ptr;
   assign wrap_pulse     = r_wrap;
   assign drop_count     = r_drop;
   assign busy           = r_busy;

`ifdef AUDIO_RING_WRITER_PEAK_EN
   logic [15:0] r_peak_l, r_peak_r, w_abs_l, w_abs_r;
   logic        w_took;

   function automatic logic [15:0] abs_sat(input logic [15:0] s);
      if (s == 16'h8000) return 16'h7FFF;
      return s[15] ? 16'(~s + 16'd1) : s;
   endfunction

   assign w_took  = w_push | w_bypass;
   assign w_abs_l = abs_sat(in_left);
   assign w_abs_r = abs_sat(in_right);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_peak_l <= '0;
         r_peak_r <= '0;
      end else if (clear) begin
         r_peak_l <= '0;
         r_peak_r <= '0;
      end else if (peak_clear) begin
         r_peak_l <= w_took ? w_abs_l : '0;
         r_peak_r <= w_took ? w_abs_r : '0;
      end else if (w_took) begin
         if (w_abs_l > r_peak_l) r_peak_l <= w_abs_l;
         if (w_abs_r > r_peak_r) r_peak_r <= w_abs_r;
      end
   end

   assign peak_left  = r_peak_l;
   assign peak_right = r_peak_r;
`endif

endmodule

// File: tb/tb_audio_ring_writer.sv
// Self-checking bench for audio_ring_writer: queue-based reference model plus directed literals.
module tb_audio_ring_writer;

   localparam int unsigned AddrW  = 4;
   localparam int unsigned Depth  = 4;
   localparam int unsigned FifoAw = 2;
   localparam int          Cap    = (1 << FifoAw) + 1;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             enable = 1'b1;
   logic             clear = 1'b0;
   logic             in_valid = 1'b0;
   logic [15:0]      in_left = '0;
   logic [15:0]      in_right = '0;
   logic             avm_waitrequest = 1'b0;
   logic [AddrW-1:0] avm_address;
   logic             avm_chipselect, avm_write;
   logic [3:0]       avm_byteenable;
   logic [31:0]      avm_writedata;
   logic [AddrW-1:0] wr_ptr;
   logic             wrap_pulse, busy;
   logic [15:0]      drop_count;
`ifdef AUDIO_RING_WRITER_PEAK_EN
   logic             peak_clear = 1'b0;
   logic [15:0]      peak_left, peak_right;
`endif

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   audio_ring_writer #(.ADDR_W(AddrW), .DEPTH(Depth), .FIFO_AW(FifoAw)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .clear           (clear),
      .in_valid        (in_valid),
      .in_left         (in_left),
      .in_right        (in_right),
      .avm_address     (avm_address),
      .avm_chipselect  (avm_chipselect),
      .avm_write       (avm_write),
      .avm_byteenable  (avm_byteenable),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .wr_ptr          (wr_ptr),
      .wrap_pulse      (wrap_pulse),
      .drop_count      (drop_count),
      .busy            (busy)
`ifdef AUDIO_RING_WRITER_PEAK_EN
      ,
      .peak_clear      (peak_clear),
      .peak_left       (peak_left),
      .peak_right      (peak_right)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of accepted samples, head is on the bus when m_on_bus.
   logic [31:0] mq[$];
   bit          m_on_bus, m_pend, m_wrap;
   int          m_addr, m_ptr, m_drops, m_peak_l, m_peak_r;
   logic [31:0] m_data;

   function automatic int abs_sat(input logic [15:0] s);
      int v;
      v = int'(signed'(s));
      if (v < 0) v = -v;
      return (v > 32767) ? 32767 : v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_on_bus = 0; m_pend = 0; m_wrap = 0;
      m_addr = 0; m_ptr = 0; m_drops = 0; m_data = '0;
      m_peak_l = 0; m_peak_r = 0;
   endtask

   task automatic model_step();
      bit acc, apply, take, took, pend_old, pclr;
      pend_old = m_pend;
      acc      = m_on_bus && !avm_waitrequest;
      apply    = m_pend && (!m_on_bus || acc);
      take     = in_valid && enable && !m_pend;
      took     = 0;
      m_wrap   = acc && (m_ptr == Depth - 1);
      if (acc) begin
         void'(mq.pop_front());
         m_ptr    = (m_ptr + 1) % Depth;
         m_on_bus = 0;
      end
      if (take) begin
         if (mq.size() < Cap) begin
            mq.push_back({in_left, in_right});
            took = 1;
         end else if (m_drops < 65535) begin
            m_drops++;
         end
      end
`ifdef AUDIO_RING_WRITER_PEAK_EN
      pclr = peak_clear;
`else
      pclr = 0;
`endif
      if (clear) begin
         m_peak_l = 0; m_peak_r = 0;
      end else if (pclr) begin
         m_peak_l = took ? abs_sat(in_left) : 0;
         m_peak_r = took ? abs_sat(in_right) : 0;
      end else if (took) begin
         if (abs_sat(in_left) > m_peak_l) m_peak_l = abs_sat(in_left);
         if (abs_sat(in_right) > m_peak_r) m_peak_r = abs_sat(in_right);
      end
      if (apply) begin
         mq.delete();
         m_ptr = 0; m_drops = 0; m_on_bus = 0;
      end
      m_pend = apply ? 1'b0 : (m_pend || clear);
      if (!pend_old && !m_on_bus && mq.size() > 0) begin
         m_on_bus = 1;
         m_addr   = m_ptr;
         m_data   = mq[0];
      end
   endtask

   task automatic model_compare();
      chk("avm_write", 32'(avm_write), 32'(m_on_bus));
      chk("avm_chipselect", 32'(avm_chipselect), 32'(m_on_bus));
      chk("avm_byteenable", 32'(avm_byteenable), 32'hF);
      if (m_on_bus) begin
         chk("avm_address", 32'(avm_address), 32'(m_addr));
         chk("avm_writedata", avm_writedata, m_data);
      end
      chk("wr_ptr", 32'(wr_ptr), 32'(m_ptr));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      chk("busy", 32'(busy), 32'(mq.size() > 0 || m_pend));
`ifdef AUDIO_RING_WRITER_PEAK_EN
      chk("peak_left", 32'(peak_left), 32'(m_peak_l));
      chk("peak_right", 32'(peak_right), 32'(m_peak_r));
`endif
   endtask

   // Inputs only change at posedge+1, so values seen at negedge are those sampled next edge.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!reset_n) model_reset();
         model_compare();
         if (reset_n) model_step();
      end
   end

   logic [AddrW-1:0] log_a[$];
   logic [31:0]      log_d[$];
   int               n_wrap = 0;

   always @(posedge clk) begin
      if (reset_n && avm_write && !avm_waitrequest) begin
         log_a.push_back(avm_address);
         log_d.push_back(avm_writedata);
      end
      if (reset_n && wrap_pulse) n_wrap++;
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      log_a.delete();
      log_d.delete();
      n_wrap = 0;
   endtask

   task automatic push_n(input int n, input logic [15:0] l0, input logic [15:0] r0);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_left  = l0 + 16'(i);
         in_right = r0 + 16'(i);
         cyc();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int drops_before;
      cyc(1);
      do_reset();
      chk("reset avm_write", 32'(avm_write), 32'h0);
      chk("reset wr_ptr", 32'(wr_ptr), 32'h0);
      chk("reset drop_count", 32'(drop_count), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset byteenable", 32'(avm_byteenable), 32'hF);

      // Three samples, one-cycle latency to the bus.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_left  = 16'(2 * i + 1);
         in_right = 16'(2 * i + 2);
         cyc();
         if (i == 0) begin
            chk("latency avm_write", 32'(avm_write), 32'h1);
            chk("latency address", 32'(avm_address), 32'h0);
         end
      end
      in_valid = 1'b0;
      cyc(4);
      chk("basic write count", 32'(log_a.size()), 32'd3);
      if (log_a.size() == 3) begin
         chk("basic data0", log_d[0], 32'h00010002);
         chk("basic data1", log_d[1], 32'h00030004);
         chk("basic data2", log_d[2], 32'h00050006);
         chk("basic addr2", 32'(log_a[2]), 32'd2);
      end
      chk("basic wr_ptr", 32'(wr_ptr), 32'd3);

      // Wrap with Depth = 4.
      do_reset();
      push_n(5, 16'h0010, 16'h0020);
      cyc(4);
      chk("wrap write count", 32'(log_a.size()), 32'd5);
      if (log_a.size() == 5) begin
         chk("wrap addr3", 32'(log_a[3]), 32'd3);
         chk("wrap addr4", 32'(log_a[4]), 32'd0);
      end
      chk("wrap pulses", 32'(n_wrap), 32'd1);
      chk("wrap wr_ptr", 32'(wr_ptr), 32'd1);

      // Overflow: 8 pushes under a 10-cycle stall.
      do_reset();
      avm_waitrequest = 1'b1;
      push_n(8, 16'h0100, 16'h0200);
      cyc(2);
      chk("overflow drop_count", 32'(drop_count), 32'd3);
      chk("overflow stalled data", avm_writedata, 32'h01000200);
      chk("overflow stalled write", 32'(avm_write), 32'h1);
      avm_waitrequest = 1'b0;
      cyc(8);
      chk("overflow write count", 32'(log_a.size()), 32'd5);
      if (log_a.size() == 5) chk("overflow last data", log_d[4], 32'h01040204);

      // Clear during a stalled write.
      log_a.delete();
      log_d.delete();
      avm_waitrequest = 1'b1;
      push_n(2, 16'hAAAA, 16'h5555);
      cyc(2);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      push_n(1, 16'h7777, 16'h7777);
      cyc(2);
      avm_waitrequest = 1'b0;
      cyc(3);
      chk("clear write count", 32'(log_a.size()), 32'd1);
      if (log_a.size() == 1) begin
         chk("clear stalled addr", 32'(log_a[0]), 32'd1);
         chk("clear stalled data", log_d[0], 32'hAAAA5555);
      end
      chk("clear wr_ptr", 32'(wr_ptr), 32'd0);
      chk("clear drop_count", 32'(drop_count), 32'd0);
      chk("clear busy", 32'(busy), 32'd0);
      push_n(1, 16'h1234, 16'h5678);
      cyc(2);
      chk("post-clear count", 32'(log_a.size()), 32'd2);
      if (log_a.size() == 2) chk("post-clear addr", 32'(log_a[1]), 32'd0);

      // Disable with two queued samples while the codec keeps strobing.
      log_a.delete();
      log_d.delete();
      avm_waitrequest = 1'b1;
      push_n(2, 16'h0A00, 16'h0B00);
      drops_before = int'(drop_count);
      enable   = 1'b0;
      in_valid = 1'b1;
      cyc(2);
      avm_waitrequest = 1'b0;
      cyc(4);
      in_valid = 1'b0;
      chk("disable write count", 32'(log_a.size()), 32'd2);
      chk("disable drop_count", 32'(drop_count), 32'(drops_before));
      chk("disable busy", 32'(busy), 32'd0);
      enable = 1'b1;

`ifdef AUDIO_RING_WRITER_PEAK_EN
      do_reset();
      in_valid = 1'b1; in_left = 16'h8000; in_right = 16'h0003; cyc();
      in_left = 16'h0064; in_right = 16'h0001; cyc();
      in_valid = 1'b0;
      cyc();
      chk("peak_left sat", 32'(peak_left), 32'h7FFF);
      chk("peak_right", 32'(peak_right), 32'h3);
      peak_clear = 1'b1; in_valid = 1'b1; in_left = 16'hFFFB; in_right = 16'h0000; cyc();
      peak_clear = 1'b0; in_valid = 1'b0;
      chk("peak_left reload", 32'(peak_left), 32'h5);
      cyc(4);
`endif

      // Randomized traffic; the reference model checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         in_valid        = ($urandom_range(0, 9) < 6);
         enable          = ($urandom_range(0, 9) != 0);
         avm_waitrequest = ($urandom_range(0, 9) < 4);
         clear           = ($urandom_range(0, 49) == 0);
         in_left         = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
         in_right        = 16'($urandom);
`ifdef AUDIO_RING_WRITER_PEAK_EN
         peak_clear      = ($urandom_range(0, 29) == 0);
`endif
         cyc();
      end
      in_valid = 1'b0; clear = 1'b0; enable = 1'b1; avm_waitrequest = 1'b0;
`ifdef AUDIO_RING_WRITER_PEAK_EN
      peak_clear = 1'b0;
`endif
      cyc(12);
      chk("random drained busy", 32'(busy), 32'd0);

      // Reset in the middle of a stalled write.
      avm_waitrequest = 1'b1;
      push_n(3, 16'h0C00, 16'h0D00);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async reset avm_write", 32'(avm_write), 32'd0);
      chk("async reset busy", 32'(busy), 32'd0);
      cyc(2);
      avm_waitrequest = 1'b0;
      reset_n = 1'b1;
      cyc(4);
      chk("after reset wr_ptr", 32'(wr_ptr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
